uart_io_ctrl: RTL and testbench
===============================

UART_IO_CTRL -- requirements
Module: uart_io_ctrl

Interface
REQ-001 The block SHALL have parameter TX_DEPTH, default 4; TX FIFO entries, power of two, 2..16.
REQ-002 The block SHALL have parameter RX_DEPTH, default 4; RX FIFO entries when UART_RX_FIFO_EN is defined, power of two, 2..16.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port WEUART, input, 1 bit: store to 0x80000008 in the current cycle.
REQ-006 Port REUART, input, 1 bit: load from 0x8000000c; this load pops RX.
REQ-007 Port UARTsel, input, 2 bits: read source. 00 = RX data, 01 = TX ready, 10 = RX valid, 11 = status.
REQ-008 Port RdEn, input, 1 bit: any UART load this cycle; qualifies UARTsel.
REQ-009 Port WriteData, input, 32 bits: store data; only bits [7:0] are used.
REQ-010 Port ReadData, output, 32 bits: registered load result.
REQ-011 Port DataIn, output, 8 bits: byte presented to the UART transmitter.
REQ-012 Port DataInValid, output, 1 bit: TX FIFO not empty.
REQ-013 Port DataInReady, input, 1 bit: UART transmitter accepts DataIn.
REQ-014 Port DataOut, input, 8 bits: byte from the UART receiver.
REQ-015 Port DataOutValid, input, 1 bit: receiver byte available.
REQ-016 Port DataOutReady, output, 1 bit: RX storage not full.

Function
REQ-017 TX push: WEUART=1 SHALL write WriteData[7:0] at the TX tail on the next edge.
REQ-018 A TX push while full and not popping SHALL be dropped and SHALL set the sticky bit tx_ovf.
REQ-019 A TX push while full with a simultaneous pop SHALL be accepted; the count is unchanged.
REQ-020 TX pop: DataInValid&&DataInReady SHALL advance the head. DataIn SHALL equal the head entry combinationally; DataInValid SHALL equal count!=0.
REQ-021 RX push: DataOutValid&&DataOutReady SHALL capture DataOut. DataOutReady SHALL equal rx_count<capacity, with no combinational path from DataOutValid.
REQ-022 RX pop: REUART=1 with RX non-empty SHALL advance the head. REUART on empty SHALL be ignored and SHALL set sticky rx_udf.
REQ-023 Simultaneous RX push and pop SHALL both occur in the same edge.
REQ-024 ReadData SHALL be registered: a load in cycle N SHALL show in cycle N+1, sampled from pre-edge state. With RdEn=0, ReadData SHALL hold its value.
REQ-025 UARTsel=00: ReadData={24'b0, RX head}. On empty, ReadData SHALL be {24'b0, last popped byte}.
REQ-026 UARTsel=01: ReadData={31'b0, TX not full}.
REQ-027 UARTsel=10: ReadData={31'b0, RX not empty}.
REQ-028 UARTsel=11: ReadData={24'b0, tx_count[3:0], 2'b0, rx_udf, tx_ovf}. This read SHALL clear tx_ovf and rx_udf on the same edge.
REQ-029 A new event coinciding with the clear SHALL win, leaving the bit set.
REQ-030 Pointers SHALL wrap modulo depth. Counts SHALL be width clog2(depth)+1 and SHALL never exceed depth or underflow.

Reset
REQ-031 On reset at a clk edge, the following SHALL go to 0: both FIFO pointers and counts, tx_ovf, rx_udf, ReadData, and the last-popped byte.
REQ-032 Post-reset outputs SHALL be DataInValid=0, DataOutReady=1, DataIn=8'h00.
REQ-033 Reset mid-transfer SHALL discard FIFO contents. Handshakes asserted in the reset cycle SHALL have no effect.
REQ-034 Reset SHALL dominate WEUART, REUART, and all handshakes.

Configuration
REQ-035 Macro UART_RX_FIFO_EN defined: the RX path SHALL be an RX_DEPTH-entry FIFO per REQ-021..023.
REQ-036 Macro UART_RX_FIFO_EN undefined: RX SHALL be a single holding register (capacity 1) and RX_DEPTH is ignored.
REQ-037 Without the macro, DataOutReady SHALL be 0 while the register is full. Same-edge pop and push SHALL still both occur.
REQ-038 Without the macro, the tx_count field in REQ-028 and all TX behaviour SHALL be unchanged.

Verification
REQ-039 Reset, then UARTsel=01 read: next cycle ReadData=1, DataInValid=0, DataOutReady=1.
REQ-040 DataInReady=0; 5 stores 0x41..0x45 at TX_DEPTH=4; status read: ReadData=0x41 (tx_count=4, tx_ovf=1).
REQ-041 Then DataInReady=1: DataIn emits 0x41,0x42,0x43,0x44 on consecutive cycles. A second status read returns 0x00.
REQ-042 RX: drive 0x5A with DataOutValid. UARTsel=10 read returns 1. REUART with UARTsel=00 returns 0x5A. UARTsel=10 then returns 0.
REQ-043 RX full and REUART in the same cycle as a new DataOutValid byte: both the pop and the capture occur; count unchanged. Checked with and without UART_RX_FIFO_EN.
REQ-044 Assert reset while TX holds 3 bytes and DataInReady=1: next cycle DataInValid=0, ReadData=0, and no further bytes are emitted.

Source files
------------

// File: rtl/uart_io_ctrl_if.sv
// uart_io_ctrl_if: load/store strobes from the CPU side plus the byte
// handshakes toward the UART transmitter and receiver.
// The master modport is the surrounding system; the slave modport is uart_io_ctrl.
interface uart_io_ctrl_if;
    logic        WEUART;
    logic        REUART;
    logic [1:0]  UARTsel;
    logic        RdEn;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [7:0]  DataIn;
    logic        DataInValid;
    logic        DataInReady;
    logic [7:0]  DataOut;
    logic        DataOutValid;
    logic        DataOutReady;

    modport master (
        output WEUART, REUART, UARTsel, RdEn, WriteData,
        output DataInReady, DataOut, DataOutValid,
        input  ReadData, DataIn, DataInValid, DataOutReady
    );

    modport slave (
        input  WEUART, REUART, UARTsel, RdEn, WriteData,
        input  DataInReady, DataOut, DataOutValid,
        output ReadData, DataIn, DataInValid, DataOutReady
    );
endinterface

// File: rtl/uart_io_ctrl.sv
// uart_io_ctrl: memory-mapped UART glue. Stores to the data register feed a
// TX FIFO toward the transmitter; received bytes are buffered for loads, and
// a registered read mux returns data, ready/valid flags or sticky status.
// Optional feature macro: UART_RX_FIFO_EN (RX_DEPTH-entry RX FIFO instead of
// a single holding register).
module uart_io_ctrl #(
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    uart_io_ctrl_if.slave bus
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int TX_CW = TX_AW + 1;
    localparam logic [TX_AW-1:0] TX_PTR_ONE  = TX_AW'(1'b1);
    localparam logic [TX_CW-1:0] TX_CNT_ONE  = TX_CW'(1'b1);
    localparam logic [TX_CW-1:0] TX_CNT_FULL = TX_CW'(TX_DEPTH);

    logic [7:0]       tx_mem_r [TX_DEPTH];
    logic [TX_AW-1:0] tx_head_r;
    logic [TX_AW-1:0] tx_tail_r;
    logic [TX_CW-1:0] tx_count_r;
    logic             tx_ovf_r;
    logic             rx_udf_r;
    logic [7:0]       rx_last_r;
    logic [31:0]      rdata_r;

    logic        tx_nempty_s;
    logic        tx_full_s;
    logic        tx_pop_s;
    logic        tx_push_s;
    logic        tx_ovf_set_s;
    logic        rx_nempty_s;
    logic        rx_room_s;
    logic [7:0]  rx_head_s;
    logic        rx_pop_s;
    logic        rx_push_s;
    logic        rx_udf_set_s;
    logic        status_rd_s;
    logic [31:0] rdata_s;
    logic [23:0] unused_wdata_s;

    assign unused_wdata_s = bus.WriteData[31:8];

    // TX handshake decode; a push into a full FIFO survives only if a pop frees a slot
    always_comb begin
        tx_nempty_s  = (tx_count_r != {TX_CW{1'b0}});
        tx_full_s    = (tx_count_r == TX_CNT_FULL);
        tx_pop_s     = tx_nempty_s && bus.DataInReady;
        tx_push_s    = bus.WEUART && (!tx_full_s || tx_pop_s);
        tx_ovf_set_s = bus.WEUART && tx_full_s && !tx_pop_s;
    end

    // TX FIFO storage, wrapping pointers and occupancy count
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_head_r  <= {TX_AW{1'b0}};
            tx_tail_r  <= {TX_AW{1'b0}};
            tx_count_r <= {TX_CW{1'b0}};
        end else begin
            if (tx_push_s) begin
                tx_mem_r[tx_tail_r] <= bus.WriteData[7:0];
                tx_tail_r           <= tx_tail_r + TX_PTR_ONE;
            end
            if (tx_pop_s) begin
                tx_head_r <= tx_head_r + TX_PTR_ONE;
            end
            case ({tx_push_s, tx_pop_s})
                2'b10:   tx_count_r <= tx_count_r + TX_CNT_ONE;
                2'b01:   tx_count_r <= tx_count_r - TX_CNT_ONE;
                default: tx_count_r <= tx_count_r;
            endcase
        end
    end

`ifdef UART_RX_FIFO_EN
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int RX_CW = RX_AW + 1;
    localparam logic [RX_AW-1:0] RX_PTR_ONE  = RX_AW'(1'b1);
    localparam logic [RX_CW-1:0] RX_CNT_ONE  = RX_CW'(1'b1);
    localparam logic [RX_CW-1:0] RX_CNT_FULL = RX_CW'(RX_DEPTH);

    logic [7:0]       rx_mem_r [RX_DEPTH];
    logic [RX_AW-1:0] rx_head_r;
    logic [RX_AW-1:0] rx_tail_r;
    logic [RX_CW-1:0] rx_count_r;

    // RX FIFO occupancy and head byte
    always_comb begin
        rx_nempty_s = (rx_count_r != {RX_CW{1'b0}});
        rx_room_s   = (rx_count_r != RX_CNT_FULL);
        rx_head_s   = rx_mem_r[rx_head_r];
    end

    // RX FIFO storage, wrapping pointers and occupancy count
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_head_r  <= {RX_AW{1'b0}};
            rx_tail_r  <= {RX_AW{1'b0}};
            rx_count_r <= {RX_CW{1'b0}};
        end else begin
            if (rx_push_s) begin
                rx_mem_r[rx_tail_r] <= bus.DataOut;
                rx_tail_r           <= rx_tail_r + RX_PTR_ONE;
            end
            if (rx_pop_s) begin
                rx_head_r <= rx_head_r + RX_PTR_ONE;
            end
            case ({rx_push_s, rx_pop_s})
                2'b10:   rx_count_r <= rx_count_r + RX_CNT_ONE;
                2'b01:   rx_count_r <= rx_count_r - RX_CNT_ONE;
                default: rx_count_r <= rx_count_r;
            endcase
        end
    end
`else
    logic [7:0] rx_hold_r;
    logic       rx_valid_r;
    logic [4:0] unused_rx_depth_s;

    // RX_DEPTH has no effect with a single holding register
    assign unused_rx_depth_s = 5'(RX_DEPTH);

    // Holding register occupancy and byte
    always_comb begin
        rx_nempty_s = rx_valid_r;
        rx_room_s   = !rx_valid_r;
        rx_head_s   = rx_hold_r;
    end

    // Holding register; a same-edge pop and capture leaves it full with the new byte
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_hold_r  <= 8'h00;
            rx_valid_r <= 1'b0;
        end else begin
            if (rx_push_s) begin
                rx_hold_r <= bus.DataOut;
            end
            case ({rx_push_s, rx_pop_s})
                2'b10:   rx_valid_r <= 1'b1;
                2'b01:   rx_valid_r <= 1'b0;
                default: rx_valid_r <= rx_valid_r;
            endcase
        end
    end
`endif

    // RX handshake decode; a full buffer still captures when a load frees a slot
    always_comb begin
        rx_pop_s     = bus.REUART && rx_nempty_s;
        rx_udf_set_s = bus.REUART && !rx_nempty_s;
        rx_push_s    = bus.DataOutValid && (rx_room_s || rx_pop_s);
    end

    // Load result mux, built from pre-edge state; holds when no load is active
    always_comb begin
        status_rd_s = bus.RdEn && (bus.UARTsel == 2'b11);
        rdata_s     = rdata_r;
        if (bus.RdEn) begin
            case (bus.UARTsel)
                2'b00:   rdata_s = {24'h000000, (rx_nempty_s ? rx_head_s : rx_last_r)};
                2'b01:   rdata_s = {31'h00000000, !tx_full_s};
                2'b10:   rdata_s = {31'h00000000, rx_nempty_s};
                2'b11:   rdata_s = {24'h000000, 4'(tx_count_r), 2'b00, rx_udf_r, tx_ovf_r};
                default: rdata_s = rdata_r;
            endcase
        end else begin
            rdata_s = rdata_r;
        end
    end

    // Registered load data, sticky error flags (new event beats clear) and last popped byte
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_r   <= 32'h00000000;
            tx_ovf_r  <= 1'b0;
            rx_udf_r  <= 1'b0;
            rx_last_r <= 8'h00;
        end else begin
            rdata_r <= rdata_s;
            if (tx_ovf_set_s) begin
                tx_ovf_r <= 1'b1;
            end else if (status_rd_s) begin
                tx_ovf_r <= 1'b0;
            end
            if (rx_udf_set_s) begin
                rx_udf_r <= 1'b1;
            end else if (status_rd_s) begin
                rx_udf_r <= 1'b0;
            end
            if (rx_pop_s) begin
                rx_last_r <= rx_head_s;
            end
        end
    end

    // Transmitter/receiver side outputs; DataIn reads 0 while the TX FIFO is empty
    always_comb begin
        bus.DataInValid  = tx_nempty_s;
        bus.DataIn       = tx_nempty_s ? tx_mem_r[tx_head_r] : 8'h00;
        bus.DataOutReady = rx_room_s;
        bus.ReadData     = rdata_r;
    end
endmodule

// File: tb/tb_uart_io_ctrl.sv
// tb_uart_io_ctrl: directed vector table, corner-case sequences and random
// traffic for uart_io_ctrl, checked against a queue-based reference model.
module tb_uart_io_ctrl;
    localparam int TXD = 4;
    localparam int RXD = 4;
`ifdef UART_RX_FIFO_EN
    localparam int RXC = RXD;
`else
    localparam int RXC = 1;
`endif
    localparam logic RX_MULTI = (RXC > 1) ? 1'b1 : 1'b0;
    localparam logic O = 1'b0;
    localparam logic I = 1'b1;

    logic clk = 1'b0;
    logic reset = 1'b1;

    uart_io_ctrl_if u_if();

    uart_io_ctrl #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       we;
        logic       re;
        logic       rden;
        logic [1:0] sel;
        logic [7:0] wd;
        logic       irdy;
        logic [7:0] dout;
        logic       dov;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic [31:0] e_rd;
        logic        e_iv;
        logic        e_or;
        logic        chk_din;
        logic [7:0]  e_din;
    } vec_t;

    int checks = 0;
    int failures = 0;

    logic [7:0]  txq[$];
    logic [7:0]  rxq[$];
    logic        m_ovf = 1'b0;
    logic        m_udf = 1'b0;
    logic [7:0]  m_last = 8'h00;
    logic [31:0] m_rd = 32'h0;

    vec_t tbl[29];

    function automatic stim_t mk(input logic rst, input logic we, input logic re,
                                 input logic rden, input logic [1:0] sel, input logic [7:0] wd,
                                 input logic irdy, input logic [7:0] dout, input logic dov);
        stim_t s;
        s.rst = rst; s.we = we; s.re = re; s.rden = rden; s.sel = sel;
        s.wd = wd; s.irdy = irdy; s.dout = dout; s.dov = dov;
        return s;
    endfunction

    function automatic vec_t vec(input stim_t s, input logic [31:0] e_rd, input logic e_iv,
                                 input logic e_or, input logic chk_din, input logic [7:0] e_din);
        vec_t v;
        v.s = s; v.e_rd = e_rd; v.e_iv = e_iv; v.e_or = e_or; v.chk_din = chk_din; v.e_din = e_din;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: one clock edge of behaviour, expressed with queues
    task automatic model(input stim_t s);
        int tsz;
        int rsz;
        bit tpop;
        bit rpop;
        bit status;
        logic [31:0] nrd;
        if (s.rst) begin
            txq.delete();
            rxq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            m_last = 8'h00;
            m_rd = 32'h0;
            return;
        end
        tsz = txq.size();
        rsz = rxq.size();
        tpop = (tsz > 0) && s.irdy;
        rpop = s.re && (rsz > 0);
        status = s.rden && (s.sel == 2'd3);
        nrd = m_rd;
        if (s.rden) begin
            case (s.sel)
                2'd0:    nrd = {24'h0, ((rsz > 0) ? rxq[0] : m_last)};
                2'd1:    nrd = (tsz < TXD) ? 32'd1 : 32'd0;
                2'd2:    nrd = (rsz > 0) ? 32'd1 : 32'd0;
                default: nrd = 32'((tsz % 16) * 16 + (m_udf ? 2 : 0) + (m_ovf ? 1 : 0));
            endcase
        end
        if (s.we && tsz == TXD && !tpop) m_ovf = 1'b1;
        else if (status) m_ovf = 1'b0;
        if (s.re && rsz == 0) m_udf = 1'b1;
        else if (status) m_udf = 1'b0;
        if (tpop) void'(txq.pop_front());
        if (s.we && (tsz < TXD || tpop)) txq.push_back(s.wd);
        if (rpop) m_last = rxq.pop_front();
        if (s.dov && (rsz < RXC || rpop)) rxq.push_back(s.dout);
        m_rd = nrd;
    endtask

    // One clock: drive at the falling edge, update the model at the rising edge, compare 1 ns later
    task automatic step(input stim_t s);
        @(negedge clk);
        reset              = s.rst;
        u_if.WEUART        = s.we;
        u_if.REUART        = s.re;
        u_if.RdEn          = s.rden;
        u_if.UARTsel       = s.sel;
        u_if.WriteData     = {24'hA5A5A5, s.wd};
        u_if.DataInReady   = s.irdy;
        u_if.DataOut       = s.dout;
        u_if.DataOutValid  = s.dov;
        @(posedge clk);
        model(s);
        #1;
        chk("model_rdata", u_if.ReadData, m_rd);
        chk("model_in_valid", {31'h0, u_if.DataInValid}, {31'h0, (txq.size() != 0)});
        chk("model_out_ready", {31'h0, u_if.DataOutReady}, {31'h0, (rxq.size() < RXC)});
        if (txq.size() != 0) chk("model_din", {24'h0, u_if.DataIn}, {24'h0, txq[0]});
    endtask

    stim_t idle;

    initial begin
        u_if.WEUART = 1'b0; u_if.REUART = 1'b0; u_if.RdEn = 1'b0; u_if.UARTsel = 2'd0;
        u_if.WriteData = 32'h0; u_if.DataInReady = 1'b0; u_if.DataOut = 8'h00; u_if.DataOutValid = 1'b0;
        idle = mk(O, O, O, O, 2'd0, 8'h00, O, 8'h00, O);

        // Directed vectors: reset, TX overflow/drain, RX push/pop/underflow, set-beats-clear
        tbl[0]  = vec(mk(I, O, O, O, 2'd0, 8'h00, O, 8'h00, O), 32'h00, O, I, I, 8'h00);
        tbl[1]  = vec(mk(O, O, O, I, 2'd1, 8'h00, O, 8'h00, O), 32'h01, O, I, I, 8'h00);
        tbl[2]  = vec(mk(O, I, O, O, 2'd0, 8'h41, O, 8'h00, O), 32'h01, I, I, I, 8'h41);
        tbl[3]  = vec(mk(O, I, O, O, 2'd0, 8'h42, O, 8'h00, O), 32'h01, I, I, I, 8'h41);
        tbl[4]  = vec(mk(O, I, O, O, 2'd0, 8'h43, O, 8'h00, O), 32'h01, I, I, I, 8'h41);
        tbl[5]  = vec(mk(O, I, O, O, 2'd0, 8'h44, O, 8'h00, O), 32'h01, I, I, I, 8'h41);
        tbl[6]  = vec(mk(O, I, O, O, 2'd0, 8'h45, O, 8'h00, O), 32'h01, I, I, I, 8'h41);
        tbl[7]  = vec(mk(O, O, O, I, 2'd3, 8'h00, O, 8'h00, O), 32'h41, I, I, I, 8'h41);
        tbl[8]  = vec(mk(O, O, O, O, 2'd0, 8'h00, I, 8'h00, O), 32'h41, I, I, I, 8'h42);
        tbl[9]  = vec(mk(O, O, O, O, 2'd0, 8'h00, I, 8'h00, O), 32'h41, I, I, I, 8'h43);
        tbl[10] = vec(mk(O, O, O, O, 2'd0, 8'h00, I, 8'h00, O), 32'h41, I, I, I, 8'h44);
        tbl[11] = vec(mk(O, O, O, O, 2'd0, 8'h00, I, 8'h00, O), 32'h41, O, I, O, 8'h00);
        tbl[12] = vec(mk(O, O, O, I, 2'd3, 8'h00, O, 8'h00, O), 32'h00, O, I, O, 8'h00);
        tbl[13] = vec(mk(O, O, O, O, 2'd0, 8'h00, O, 8'h5A, I), 32'h00, O, RX_MULTI, O, 8'h00);
        tbl[14] = vec(mk(O, O, O, I, 2'd2, 8'h00, O, 8'h00, O), 32'h01, O, RX_MULTI, O, 8'h00);
        tbl[15] = vec(mk(O, O, I, I, 2'd0, 8'h00, O, 8'h00, O), 32'h5A, O, I, O, 8'h00);
        tbl[16] = vec(mk(O, O, O, I, 2'd2, 8'h00, O, 8'h00, O), 32'h00, O, I, O, 8'h00);
        tbl[17] = vec(mk(O, O, O, I, 2'd0, 8'h00, O, 8'h00, O), 32'h5A, O, I, O, 8'h00);
        tbl[18] = vec(mk(O, O, I, O, 2'd0, 8'h00, O, 8'h00, O), 32'h5A, O, I, O, 8'h00);
        tbl[19] = vec(mk(O, O, O, I, 2'd3, 8'h00, O, 8'h00, O), 32'h02, O, I, O, 8'h00);
        tbl[20] = vec(mk(O, O, O, I, 2'd3, 8'h00, O, 8'h00, O), 32'h00, O, I, O, 8'h00);
        tbl[21] = vec(mk(O, I, O, O, 2'd0, 8'h10, O, 8'h00, O), 32'h00, I, I, I, 8'h10);
        tbl[22] = vec(mk(O, I, O, O, 2'd0, 8'h11, O, 8'h00, O), 32'h00, I, I, I, 8'h10);
        tbl[23] = vec(mk(O, I, O, O, 2'd0, 8'h12, O, 8'h00, O), 32'h00, I, I, I, 8'h10);
        tbl[24] = vec(mk(O, I, O, O, 2'd0, 8'h13, O, 8'h00, O), 32'h00, I, I, I, 8'h10);
        tbl[25] = vec(mk(O, I, O, I, 2'd3, 8'h14, O, 8'h00, O), 32'h40, I, I, I, 8'h10);
        tbl[26] = vec(mk(O, O, O, I, 2'd3, 8'h00, O, 8'h00, O), 32'h41, I, I, I, 8'h10);
        tbl[27] = vec(mk(O, O, O, I, 2'd1, 8'h00, O, 8'h00, O), 32'h00, I, I, I, 8'h10);
        tbl[28] = vec(mk(I, O, O, O, 2'd0, 8'h00, O, 8'h00, O), 32'h00, O, I, I, 8'h00);

        for (int i = 0; i < 29; i++) begin
            step(tbl[i].s);
            chk($sformatf("row%0d_rdata", i), u_if.ReadData, tbl[i].e_rd);
            chk($sformatf("row%0d_in_valid", i), {31'h0, u_if.DataInValid}, {31'h0, tbl[i].e_iv});
            chk($sformatf("row%0d_out_ready", i), {31'h0, u_if.DataOutReady}, {31'h0, tbl[i].e_or});
            if (tbl[i].chk_din) chk($sformatf("row%0d_din", i), {24'h0, u_if.DataIn}, {24'h0, tbl[i].e_din});
        end

        // RX full with a load and a new byte on the same edge: both happen, occupancy unchanged
        for (int i = 0; i < RXC; i++) step(mk(O, O, O, O, 2'd0, 8'h00, O, 8'(8'h80 + i), I));
        chk("rxfull_ready_low", {31'h0, u_if.DataOutReady}, 32'h0);
        step(mk(O, O, I, I, 2'd0, 8'h00, O, 8'hC0, I));
        chk("rxfull_pop_data", u_if.ReadData, 32'h80);
        chk("rxfull_still_full", {31'h0, u_if.DataOutReady}, 32'h0);
        for (int i = 0; i < RXC; i++) begin
            step(mk(O, O, I, I, 2'd0, 8'h00, O, 8'h00, O));
            chk($sformatf("rxfull_drain%0d", i), u_if.ReadData,
                (i < RXC - 1) ? 32'(8'h81 + i) : 32'hC0);
        end
        step(mk(O, O, O, I, 2'd2, 8'h00, O, 8'h00, O));
        chk("rxfull_empty_after", u_if.ReadData, 32'h0);

        // Reset while TX holds three bytes and the transmitter is ready
        step(mk(O, I, O, O, 2'd0, 8'h61, O, 8'h00, O));
        step(mk(O, I, O, O, 2'd0, 8'h62, O, 8'h00, O));
        step(mk(O, I, O, O, 2'd0, 8'h63, O, 8'h00, O));
        step(mk(O, O, O, I, 2'd3, 8'h00, O, 8'h00, O));
        chk("midrst_status", u_if.ReadData, 32'h30);
        step(mk(I, I, I, I, 2'd1, 8'h77, I, 8'h99, I));
        chk("midrst_in_valid", {31'h0, u_if.DataInValid}, 32'h0);
        chk("midrst_rdata", u_if.ReadData, 32'h0);
        chk("midrst_out_ready", {31'h0, u_if.DataOutReady}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            step(mk(O, O, O, O, 2'd0, 8'h00, I, 8'h00, O));
            chk($sformatf("midrst_no_emit%0d", i), {31'h0, u_if.DataInValid}, 32'h0);
        end

        // Random traffic against the model
        for (int n = 0; n < 800; n++) begin
            stim_t s;
            s.rst  = ($urandom_range(0, 79) == 0);
            s.we   = ($urandom_range(0, 2) == 0);
            s.re   = ($urandom_range(0, 3) == 0);
            s.rden = ($urandom_range(0, 1) == 0);
            s.sel  = 2'($urandom_range(0, 3));
            s.wd   = 8'($urandom);
            s.irdy = ($urandom_range(0, 2) == 0);
            s.dout = 8'($urandom);
            s.dov  = ($urandom_range(0, 2) == 0);
            step(s);
        end
        step(idle);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
